alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 24 ++
 rtl/alu_arbiter.sv | 81 ++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, ALU and response signals of the two-requester ALU arbiter.
// The arbiter takes the slave modport; the requesters, ALU and response sink take master.
interface alu_arbiter_if;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_sel, req1_sel;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_sel;
    logic       alu_carry;
    logic       rsp_valid, rsp_ready, rsp_carry, rsp_id, rsp_err, busy;
    logic [7:0] rsp_data;
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sel, req1_sel,
        input  alu_out, alu_carry, rsp_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_sel,
        output rsp_valid, rsp_data, rsp_carry, rsp_id, rsp_err, busy
    );
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sel, req1_sel,
        output alu_out, alu_carry, rsp_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_sel,
        input  rsp_valid, rsp_data, rsp_carry, rsp_id, rsp_err, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one fixed-latency ALU between two requesters.
// Optional macro ALU_ARB_DIV0_CHK_EN answers divide-by-zero locally with 8'hFF and rsp_err.
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input logic         clock,
    input logic         reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t     state;
    logic [2:0] cnt;
    logic       last, gnt, acc, div0;
    logic [7:0] acc_a, acc_b;
    logic [3:0] acc_sel;
    // requester 1 wins only when alone or when requester 0 was served last
    assign gnt            = bus.req0_valid && bus.req1_valid ? ~last : bus.req1_valid;
    assign bus.req0_ready = reset && state == IDLE && bus.req0_valid && !gnt;
    assign bus.req1_ready = reset && state == IDLE && bus.req1_valid && gnt;
    assign acc            = bus.req0_ready || bus.req1_ready;
    assign acc_a          = gnt ? bus.req1_a : bus.req0_a;
    assign acc_b          = gnt ? bus.req1_b : bus.req0_b;
    assign acc_sel        = gnt ? bus.req1_sel : bus.req0_sel;
`ifdef ALU_ARB_DIV0_CHK_EN
    assign div0 = acc_sel == 4'b0011 && acc_b == 8'd0;
`else
    assign div0 = 1'b0;
`endif
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            last          <= 1'b1;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_sel   <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_carry <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (acc) begin
                    bus.rsp_id <= gnt;
                    last       <= gnt;
                    bus.busy   <= 1'b1;
                    if (div0) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= 8'hFF;
                        bus.rsp_carry <= 1'b0;
                        bus.rsp_err   <= 1'b1;
                    end else begin
                        bus.alu_a   <= acc_a;
                        bus.alu_b   <= acc_b;
                        bus.alu_sel <= acc_sel;
                        cnt         <= 3'(ALU_LAT);
                        state       <= WAIT;
                    end
                end
                WAIT: if (cnt == 3'd0) begin
                    bus.rsp_data  <= bus.alu_out;
                    bus.rsp_carry <= bus.alu_carry;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end else begin
                    cnt <= cnt - 3'd1;
                end
                RESP: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
